// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, grant identities
// and the two-way round-robin pick.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_INST  = 2'd1,
    ARB_LOAD  = 2'd2,
    ARB_STORE = 2'd3
  } arb_state_e;

  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  // A lone LSU request always wins. On a tie the LSU wins only when IF
  // was granted last.
  function automatic logic pick_lsu(input logic ifp, input logic lp, input logic last);
    return lp & (~ifp | (last == GRANT_IF));
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the requester-side (IF, LSU) and memctrl-side signals of the
// memory arbiter.
//   master : the arbiter; drives the mc_* requests and the IF/LSU responses
//   slave  : the environment; drives requests, operands and memctrl answers
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [31:0]       if_data;

  logic              lsu_req;
  logic              lsu_we;
  logic [ADDR_W-1:0] lsu_addr;
  logic [1:0]        lsu_len;
  logic [31:0]       lsu_wdata;
  logic              lsu_done;
  logic [31:0]       lsu_rdata;

  logic              mc_read_inst;
  logic [ADDR_W-1:0] mc_read_inst_addr;
  logic [31:0]       mc_read_inst_ans;
  logic              mc_read_inst_ok;

  logic              mc_read_data;
  logic [ADDR_W-1:0] mc_read_data_addr;
  logic [1:0]        mc_read_data_len;
  logic [31:0]       mc_read_data_ans;
  logic              mc_read_data_ok;

  logic              mc_write_data;
  logic [ADDR_W-1:0] mc_write_data_addr;
  logic [1:0]        mc_write_data_len;
  logic [31:0]       mc_write_data_val;
  logic              mc_write_data_ok;

  modport master (
    input  if_req, if_addr,
    input  lsu_req, lsu_we, lsu_addr, lsu_len, lsu_wdata,
    input  mc_read_inst_ans, mc_read_inst_ok,
    input  mc_read_data_ans, mc_read_data_ok,
    input  mc_write_data_ok,
    output if_valid, if_data, lsu_done, lsu_rdata,
    output mc_read_inst, mc_read_inst_addr,
    output mc_read_data, mc_read_data_addr, mc_read_data_len,
    output mc_write_data, mc_write_data_addr, mc_write_data_len, mc_write_data_val
  );

  modport slave (
    output if_req, if_addr,
    output lsu_req, lsu_we, lsu_addr, lsu_len, lsu_wdata,
    output mc_read_inst_ans, mc_read_inst_ok,
    output mc_read_data_ans, mc_read_data_ok,
    output mc_write_data_ok,
    input  if_valid, if_data, lsu_done, lsu_rdata,
    input  mc_read_inst, mc_read_inst_addr,
    input  mc_read_data, mc_read_data_addr, mc_read_data_len,
    input  mc_write_data, mc_write_data_addr, mc_write_data_len, mc_write_data_val
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store in front of
// memctrl. One memory operation outstanding at a time; operands and strobe
// are held until memctrl answers; an IF flush discards an in-flight fetch.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   rdy    global enable; 0 freezes every register
//   flush  cancels the current or pending instruction fetch
//   bus    requester and memctrl signals (mem_arbiter_if.master)
//
// state     | meaning
// ----------+------------------------------------------------
// ARB_IDLE  | no op outstanding; arbitrate IF vs LSU
// ARB_INST  | fetch strobe held until read_inst_ok
// ARB_LOAD  | load strobe held until read_data_ok
// ARB_STORE | store strobe held until write_data_ok
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int   ADDR_W    = 32,
  parameter logic INIT_LAST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          flush,
  mem_arbiter_if.master bus
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              drop_q, drop_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_data_q, if_data_d;
  logic              lsu_done_q, lsu_done_d;
  logic [31:0]       lsu_rdata_q, lsu_rdata_d;
  logic              inst_q, inst_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        rd_len_q, rd_len_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]        wr_len_q, wr_len_d;
  logic [31:0]       wr_val_q, wr_val_d;
  logic              ifp, lp;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    drop_d      = drop_q;
    if_valid_d  = if_valid_q;
    if_data_d   = if_data_q;
    lsu_done_d  = lsu_done_q;
    lsu_rdata_d = lsu_rdata_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    rd_d        = rd_q;
    rd_addr_d   = rd_addr_q;
    rd_len_d    = rd_len_q;
    wr_d        = wr_q;
    wr_addr_d   = wr_addr_q;
    wr_len_d    = wr_len_q;
    wr_val_d    = wr_val_q;
    ifp         = 1'b0;
    lp          = 1'b0;

    if (rdy) begin
      if_valid_d = 1'b0;
      lsu_done_d = 1'b0;
      case (state_q)
        ARB_IDLE: begin
          // While a requester's completion pulse is showing, its req line is
          // still the one for the op just served; it competes next cycle.
          ifp = bus.if_req & ~flush & ~if_valid_q;
          lp  = bus.lsu_req & ~lsu_done_q;
          if (ifp | lp) begin
            drop_d = 1'b0;
            if (pick_lsu(ifp, lp, last_q)) begin
              last_d = GRANT_LSU;
              if (bus.lsu_we) begin
                wr_d      = 1'b1;
                wr_addr_d = bus.lsu_addr;
                wr_len_d  = bus.lsu_len;
                wr_val_d  = bus.lsu_wdata;
                state_d   = ARB_STORE;
              end else begin
                rd_d      = 1'b1;
                rd_addr_d = bus.lsu_addr;
                rd_len_d  = bus.lsu_len;
                state_d   = ARB_LOAD;
              end
            end else begin
              last_d      = GRANT_IF;
              inst_d      = 1'b1;
              inst_addr_d = bus.if_addr;
              state_d     = ARB_INST;
            end
          end
        end
        ARB_INST: begin
          if (flush) drop_d = 1'b1;
          if (bus.mc_read_inst_ok) begin
            inst_d  = 1'b0;
            drop_d  = 1'b0;
            state_d = ARB_IDLE;
            // A flush in the same cycle as ok still discards the result.
            if (!(drop_q | flush)) begin
              if_data_d  = bus.mc_read_inst_ans;
              if_valid_d = 1'b1;
            end
          end
        end
        ARB_LOAD: begin
          if (bus.mc_read_data_ok) begin
            rd_d        = 1'b0;
            lsu_rdata_d = bus.mc_read_data_ans;
            lsu_done_d  = 1'b1;
            state_d     = ARB_IDLE;
          end
        end
        ARB_STORE: begin
          if (bus.mc_write_data_ok) begin
            wr_d       = 1'b0;
            lsu_done_d = 1'b1;
            state_d    = ARB_IDLE;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      last_q      <= INIT_LAST;
      drop_q      <= 1'b0;
      if_valid_q  <= 1'b0;
      if_data_q   <= '0;
      lsu_done_q  <= 1'b0;
      lsu_rdata_q <= '0;
      inst_q      <= 1'b0;
      inst_addr_q <= '0;
      rd_q        <= 1'b0;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      wr_q        <= 1'b0;
      wr_addr_q   <= '0;
      wr_len_q    <= '0;
      wr_val_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      drop_q      <= drop_d;
      if_valid_q  <= if_valid_d;
      if_data_q   <= if_data_d;
      lsu_done_q  <= lsu_done_d;
      lsu_rdata_q <= lsu_rdata_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      rd_q        <= rd_d;
      rd_addr_q   <= rd_addr_d;
      rd_len_q    <= rd_len_d;
      wr_q        <= wr_d;
      wr_addr_q   <= wr_addr_d;
      wr_len_q    <= wr_len_d;
      wr_val_q    <= wr_val_d;
    end
  end

  assign bus.if_valid           = if_valid_q;
  assign bus.if_data            = if_data_q;
  assign bus.lsu_done           = lsu_done_q;
  assign bus.lsu_rdata          = lsu_rdata_q;
  assign bus.mc_read_inst       = inst_q;
  assign bus.mc_read_inst_addr  = inst_addr_q;
  assign bus.mc_read_data       = rd_q;
  assign bus.mc_read_data_addr  = rd_addr_q;
  assign bus.mc_read_data_len   = rd_len_q;
  assign bus.mc_write_data      = wr_q;
  assign bus.mc_write_data_addr = wr_addr_q;
  assign bus.mc_write_data_len  = wr_len_q;
  assign bus.mc_write_data_val  = wr_val_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk;
  logic rst;
  logic rdy;
  logic flush;

  int tests_run = 0;
  int tests_failed = 0;

  mem_arbiter_if #(.ADDR_W(32)) bus();

  mem_arbiter #(.ADDR_W(32), .INIT_LAST(1'b1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ans_of(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // ---------------- memctrl model ----------------
  int          lat = 2;
  logic        m_busy, m_rest;
  logic [1:0]  m_kind;
  int          m_cnt;
  logic [31:0] m_addr, m_val, m_ans;
  logic [1:0]  m_len;
  logic        m_inst_ok, m_data_ok, m_wr_ok;
  logic        s_inst_ok = 1'b0, s_data_ok = 1'b0, s_wr_ok = 1'b0;
  int          hold_err = 0;
  logic        gl_q[$];

  assign bus.mc_read_inst_ok  = m_inst_ok | s_inst_ok;
  assign bus.mc_read_data_ok  = m_data_ok | s_data_ok;
  assign bus.mc_write_data_ok = m_wr_ok | s_wr_ok;
  assign bus.mc_read_inst_ans = m_ans;
  assign bus.mc_read_data_ans = m_ans;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_rest <= 1'b0; m_kind <= 2'd0; m_cnt <= 0;
      m_addr <= '0; m_val <= '0; m_len <= '0; m_ans <= '0;
      m_inst_ok <= 1'b0; m_data_ok <= 1'b0; m_wr_ok <= 1'b0;
    end else if (rdy) begin
      if (!m_busy) begin
        m_inst_ok <= 1'b0; m_data_ok <= 1'b0; m_wr_ok <= 1'b0;
        if (m_rest) m_rest <= 1'b0;
        else if (bus.mc_read_inst | bus.mc_read_data | bus.mc_write_data) begin
          if ((bus.mc_read_inst & bus.mc_read_data) | (bus.mc_read_inst & bus.mc_write_data) |
              (bus.mc_read_data & bus.mc_write_data)) hold_err <= hold_err + 1;
          m_busy <= 1'b1;
          m_cnt  <= lat;
          if (bus.mc_read_inst) begin
            m_kind <= 2'd0; m_addr <= bus.mc_read_inst_addr; m_len <= '0; m_val <= '0;
            gl_q.push_back(1'b0);
          end else if (bus.mc_read_data) begin
            m_kind <= 2'd1; m_addr <= bus.mc_read_data_addr; m_len <= bus.mc_read_data_len; m_val <= '0;
            gl_q.push_back(1'b1);
          end else begin
            m_kind <= 2'd2; m_addr <= bus.mc_write_data_addr; m_len <= bus.mc_write_data_len;
            m_val <= bus.mc_write_data_val;
            gl_q.push_back(1'b1);
          end
        end
      end else begin
        case (m_kind)
          2'd0: if (!bus.mc_read_inst || bus.mc_read_inst_addr !== m_addr ||
                    bus.mc_read_data || bus.mc_write_data) hold_err <= hold_err + 1;
          2'd1: if (!bus.mc_read_data || bus.mc_read_data_addr !== m_addr || bus.mc_read_data_len !== m_len ||
                    bus.mc_read_inst || bus.mc_write_data) hold_err <= hold_err + 1;
          default: if (!bus.mc_write_data || bus.mc_write_data_addr !== m_addr || bus.mc_write_data_len !== m_len ||
                       bus.mc_write_data_val !== m_val || bus.mc_read_inst || bus.mc_read_data) hold_err <= hold_err + 1;
        endcase
        if (m_cnt <= 1) begin
          m_busy <= 1'b0;
          m_rest <= 1'b1;
          m_ans  <= ans_of(m_addr);
          case (m_kind)
            2'd0:    m_inst_ok <= 1'b1;
            2'd1:    m_data_ok <= 1'b1;
            default: m_wr_ok   <= 1'b1;
          endcase
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] if_exp[$];
  logic [32:0] lsu_exp[$];   // {is_load, data}
  logic [31:0] e_if;
  logic [32:0] e_lsu;
  int          if_served = 0;
  int          lsu_served = 0;

  always @(negedge clk) begin
    if (rst === 1'b1 && rdy === 1'b1) begin
      if (bus.if_valid === 1'b1) begin
        tests_run++;
        if (if_exp.size() == 0) begin
          tests_failed++;
          $display("FAIL if_result: unexpected if_valid with if_data=%h, no fetch outstanding", bus.if_data);
        end else begin
          e_if = if_exp.pop_front();
          if (bus.if_data !== e_if) begin
            tests_failed++;
            $display("FAIL if_result: if_data=%h required %h", bus.if_data, e_if);
          end
        end
        if_served++;
      end
      if (bus.lsu_done === 1'b1) begin
        tests_run++;
        if (lsu_exp.size() == 0) begin
          tests_failed++;
          $display("FAIL lsu_result: unexpected lsu_done, no LSU op outstanding");
        end else begin
          e_lsu = lsu_exp.pop_front();
          if (e_lsu[32] && bus.lsu_rdata !== e_lsu[31:0]) begin
            tests_failed++;
            $display("FAIL lsu_result: lsu_rdata=%h required %h", bus.lsu_rdata, e_lsu[31:0]);
          end
        end
        lsu_served++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (bus.mc_read_inst | bus.mc_read_data | bus.mc_write_data) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_until(input int if_tgt, input int lsu_tgt, input int budget, output bit done);
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (if_served >= if_tgt) bus.if_req = 1'b0;
      if (lsu_served >= lsu_tgt) bus.lsu_req = 1'b0;
      if (if_served >= if_tgt && lsu_served >= lsu_tgt) begin
        done = 1'b1;
        break;
      end
    end
    bus.if_req  = 1'b0;
    bus.lsu_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit seen, done;
    int bi, bl;
    rst = 1'b0;
    repeat (2) step();
    tests_run++;
    if ({bus.mc_read_inst, bus.mc_read_data, bus.mc_write_data, bus.if_valid, bus.lsu_done} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: strobes/pulses=%b required 00000",
               {bus.mc_read_inst, bus.mc_read_data, bus.mc_write_data, bus.if_valid, bus.lsu_done});
    end
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    wait_strobe(20, seen);
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL reset_first_fetch: no strobe within 20 cycles, required one"); end
    step();
    tests_run++;
    if (dut.state_q !== ARB_INST) begin
      tests_failed++; $display("FAIL mid_inst_state: state=%0d required %0d", dut.state_q, ARB_INST);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.mc_read_inst, bus.mc_read_data, bus.mc_write_data} !== 3'b0 || bus.mc_read_inst_addr !== 32'h0 ||
        dut.state_q !== ARB_IDLE || dut.last_q !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset: strobes=%b addr=%h state=%0d last=%b required 000 0 IDLE 1",
               {bus.mc_read_inst, bus.mc_read_data, bus.mc_write_data}, bus.mc_read_inst_addr, dut.state_q, dut.last_q);
    end
    if_exp.delete(); lsu_exp.delete();
    step();
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h2000; bus.lsu_len = 2'd3;
    if_exp.push_back(ans_of(32'h300));
    lsu_exp.push_back({1'b1, ans_of(32'h2000)});
    bi = if_served; bl = lsu_served;
    rst = 1'b1;
    step();
    tests_run++;
    if (bus.mc_read_inst !== 1'b1 || bus.mc_read_data !== 1'b0 || bus.mc_read_inst_addr !== 32'h300) begin
      tests_failed++;
      $display("FAIL tie_after_reset: inst=%b data=%b addr=%h required 1 0 00000300",
               bus.mc_read_inst, bus.mc_read_data, bus.mc_read_inst_addr);
    end
    run_until(bi + 1, bl + 1, 100, done);
    tests_run++;
    if (!done) begin tests_failed++; $display("FAIL reset_ops_done: served if=%0d lsu=%0d required %0d %0d", if_served, lsu_served, bi + 1, bl + 1); end
  endtask

  task automatic test_single_fetch();
    int bi, bad_addr, ok_cyc, pulse_cyc, n;
    lat = 5;
    bi = if_served; bad_addr = 0; ok_cyc = -1; pulse_cyc = -1;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    if_exp.push_back(32'hDEADBEEF);
    for (n = 0; n < 60 && if_served == bi; n++) begin
      step();
      if (bus.mc_read_inst && bus.mc_read_inst_addr !== 32'h100) bad_addr++;
      if (bus.mc_read_inst_ok && ok_cyc < 0) ok_cyc = n;
      if (bus.if_valid && pulse_cyc < 0) pulse_cyc = n;
    end
    bus.if_req = 1'b0;
    tests_run++;
    if (if_served != bi + 1) begin tests_failed++; $display("FAIL fetch_done: served=%0d required %0d", if_served, bi + 1); end
    tests_run++;
    if (bad_addr != 0) begin tests_failed++; $display("FAIL fetch_addr_hold: %0d cycles off 0x100, required 0", bad_addr); end
    tests_run++;
    if (pulse_cyc - ok_cyc != 1) begin
      tests_failed++; $display("FAIL fetch_latency: ok->if_valid=%0d cycles required 1", pulse_cyc - ok_cyc);
    end
    step();
    tests_run++;
    if (bus.if_valid !== 1'b0) begin tests_failed++; $display("FAIL if_valid_width: if_valid=%b required 0", bus.if_valid); end
  endtask

  task automatic test_store();
    int bl, bad_op, read_seen, n;
    lat = 3;
    bl = lsu_served; bad_op = 0; read_seen = 0;
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 32'h30004; bus.lsu_len = 2'd0; bus.lsu_wdata = 32'h0000_00AB;
    lsu_exp.push_back({1'b0, 32'h0});
    for (n = 0; n < 60 && lsu_served == bl; n++) begin
      step();
      if (bus.mc_write_data && (bus.mc_write_data_len !== 2'd0 || bus.mc_write_data_val !== 32'hAB ||
                                bus.mc_write_data_addr !== 32'h30004)) bad_op++;
      if (bus.mc_read_inst || bus.mc_read_data) read_seen++;
    end
    bus.lsu_req = 1'b0; bus.lsu_we = 1'b0;
    tests_run++;
    if (lsu_served != bl + 1) begin tests_failed++; $display("FAIL store_done: served=%0d required %0d", lsu_served, bl + 1); end
    tests_run++;
    if (bad_op != 0) begin tests_failed++; $display("FAIL store_operands: %0d bad cycles, required 0", bad_op); end
    tests_run++;
    if (read_seen != 0) begin tests_failed++; $display("FAIL store_no_reads: %0d read strobe cycles, required 0", read_seen); end
    step();
    tests_run++;
    if (bus.lsu_done !== 1'b0 || bus.mc_write_data !== 1'b0) begin
      tests_failed++; $display("FAIL store_after: lsu_done=%b write=%b required 0 0", bus.lsu_done, bus.mc_write_data);
    end
  endtask

  task automatic test_alternate();
    int bi, bl;
    bit done;
    logic [3:0] order;
    lat = 2;
    gl_q.delete();
    bi = if_served; bl = lsu_served;
    bus.if_req = 1'b1; bus.if_addr = 32'h140;
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h2000; bus.lsu_len = 2'd3;
    repeat (2) begin
      if_exp.push_back(ans_of(32'h140));
      lsu_exp.push_back({1'b1, ans_of(32'h2000)});
    end
    run_until(bi + 2, bl + 2, 200, done);
    repeat (3) step();
    tests_run++;
    if (!done) begin tests_failed++; $display("FAIL alt_done: served if=%0d lsu=%0d required %0d %0d", if_served, lsu_served, bi + 2, bl + 2); end
    order = 4'hF;
    if (gl_q.size() >= 4) order = {gl_q[0], gl_q[1], gl_q[2], gl_q[3]};
    tests_run++;
    if (gl_q.size() != 4 || order !== 4'b0101) begin
      tests_failed++; $display("FAIL alt_order: grants=%0d order=%b required 4 0101", gl_q.size(), order);
    end
  endtask

  task automatic test_flush();
    int bi, seen200, early, n;
    bit seen;
    lat = 4;
    bus.if_req = 1'b1; bus.if_addr = 32'h180;
    flush = 1'b1;
    step();
    tests_run++;
    if (bus.mc_read_inst !== 1'b0) begin tests_failed++; $display("FAIL flush_blocks_grant: inst=%b required 0", bus.mc_read_inst); end
    flush = 1'b0;
    wait_strobe(20, seen);
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL flush_fetch_start: no strobe within 20 cycles, required one"); end
    step(); step();
    flush = 1'b1; bus.if_addr = 32'h200;
    step();
    flush = 1'b0;
    if_exp.push_back(ans_of(32'h200));
    bi = if_served; seen200 = 0; early = 0;
    for (n = 0; n < 80 && if_served == bi; n++) begin
      step();
      if (bus.mc_read_inst && bus.mc_read_inst_addr === 32'h200) seen200 = 1;
      if (bus.if_valid && !seen200) early++;
    end
    bus.if_req = 1'b0;
    tests_run++;
    if (if_served != bi + 1 || seen200 != 1) begin
      tests_failed++; $display("FAIL flush_refetch: served=%0d grant200=%0d required %0d 1", if_served, seen200, bi + 1);
    end
    tests_run++;
    if (early != 0) begin tests_failed++; $display("FAIL flush_drop: %0d if_valid for flushed fetch, required 0", early); end
  endtask

  task automatic test_rdy_freeze();
    int bl, bad;
    bit seen, done;
    lat = 3;
    bl = lsu_served; bad = 0;
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h2040; bus.lsu_len = 2'd1;
    lsu_exp.push_back({1'b1, ans_of(32'h2040)});
    wait_strobe(20, seen);
    step();
    rdy = 1'b0;
    repeat (4) begin
      step();
      if (bus.mc_read_data !== 1'b1 || bus.mc_read_data_addr !== 32'h2040 || bus.mc_read_data_len !== 2'd1 ||
          bus.lsu_done !== 1'b0 || dut.state_q !== ARB_LOAD) bad++;
    end
    rdy = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests_run++;
    if (!seen || bad != 0) begin tests_failed++; $display("FAIL rdy_freeze: strobe=%0d bad_cycles=%0d required 1 0", seen, bad); end
    run_until(if_served, bl + 1, 60, done);
    tests_run++;
    if (!done) begin tests_failed++; $display("FAIL rdy_resume: served=%0d required %0d", lsu_served, bl + 1); end
  endtask

  task automatic test_stray_ok();
    int bad, bi;
    bit seen, done;
    bad = 0;
    step();
    s_inst_ok = 1'b1; s_data_ok = 1'b1; s_wr_ok = 1'b1;
    step();
    s_inst_ok = 1'b0; s_data_ok = 1'b0; s_wr_ok = 1'b0;
    repeat (3) begin
      step();
      if (bus.if_valid || bus.lsu_done || dut.state_q !== ARB_IDLE) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL idle_ok_ignored: %0d bad cycles, required 0", bad); end
    lat = 6;
    bi = if_served;
    bus.if_req = 1'b1; bus.if_addr = 32'h220;
    if_exp.push_back(ans_of(32'h220));
    wait_strobe(20, seen);
    step();
    s_data_ok = 1'b1; s_wr_ok = 1'b1;
    step();
    s_data_ok = 1'b0; s_wr_ok = 1'b0;
    step();
    tests_run++;
    if (!seen || bus.mc_read_inst !== 1'b1 || dut.state_q !== ARB_INST) begin
      tests_failed++; $display("FAIL wrong_ok_ignored: inst=%b state=%0d required 1 %0d", bus.mc_read_inst, dut.state_q, ARB_INST);
    end
    run_until(bi + 1, lsu_served, 60, done);
    tests_run++;
    if (!done) begin tests_failed++; $display("FAIL stray_fetch_done: served=%0d required %0d", if_served, bi + 1); end
  endtask

  task automatic test_final();
    repeat (3) step();
    tests_run++;
    if (hold_err !== 0) begin tests_failed++; $display("FAIL operand_hold: %0d hold violations, required 0", hold_err); end
    tests_run++;
    if (if_exp.size() != 0 || lsu_exp.size() != 0) begin
      tests_failed++; $display("FAIL leftover: if=%0d lsu=%0d results missing, required 0 0", if_exp.size(), lsu_exp.size());
    end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_addr = '0; bus.lsu_len = '0; bus.lsu_wdata = '0;
    test_reset();
    test_single_fetch();
    test_store();
    test_alternate();
    test_flush();
    test_rdy_freeze();
    test_stray_ok();
    test_final();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the instruction-fetch unit (IF), the load/store unit (LSU) and memctrl.
- Owns memctrl's three request ports and has at most one memory operation outstanding.
- Alternates grants round-robin so neither requester is starved, as memctrl's fixed IF-first priority would otherwise allow.
- Holds request operands stable for the whole operation and supports an IF flush, which discards an in-flight fetch result.

Parameters:
ADDR_W, 32, address width on every port
INIT_LAST, 1, value of last_grant after reset (1 = LSU was last, so IF wins the first tie)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rdy  in  1  global enable; 0 freezes all state and outputs
flush  in  1  pipeline flush; cancels the current/pending IF fetch
if_req  in  1  IF fetch request (level)
if_addr  in  ADDR_W  fetch address
if_valid  out  1  one-cycle pulse: if_data valid
if_data  out  32  fetched instruction word
lsu_req  in  1  LSU request (level)
lsu_we  in  1  1 = store, 0 = load
lsu_addr  in  ADDR_W  data address
lsu_len  in  2  byte count minus 1 (0 = byte, 1 = half, 3 = word)
lsu_wdata  in  32  store data
lsu_done  out  1  one-cycle pulse: load data valid / store complete
lsu_rdata  out  32  load result (raw memctrl answer)
mc_read_inst  out  1  to memctrl read_inst
mc_read_inst_addr  out  ADDR_W  to memctrl read_inst_addr
mc_read_inst_ans  in  32  from memctrl
mc_read_inst_ok  in  1  from memctrl
mc_read_data  out  1  to memctrl read_data
mc_read_data_addr  out  ADDR_W  to memctrl read_data_addr
mc_read_data_len  out  2  to memctrl read_data_len
mc_read_data_ans  in  32  from memctrl
mc_read_data_ok  in  1  from memctrl
mc_write_data  out  1  to memctrl write_data
mc_write_data_addr  out  ADDR_W  to memctrl write_data_addr
mc_write_data_len  out  2  to memctrl write_data_len
mc_write_data_val  out  32  to memctrl write_data_val
mc_write_data_ok  in  1  from memctrl

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state=IDLE, last_grant=INIT_LAST, drop=0.
- rdy=0: no register changes and outputs hold; consumers qualify pulses with rdy.
- All outputs are registered. if_valid and lsu_done default to 0 each rdy cycle.
- States: IDLE, INST, LOAD, STORE.

IDLE grant decision, evaluated on each rdy cycle:
- ifp = if_req & ~flush; lp = lsu_req.
- ifp & lp: grant the requester that is not last_grant (last_grant: 0 = IF, 1 = LSU).
- Only one pending: grant it. Neither pending: stay in IDLE.
- On grant, register the operands into the matching mc_* address/len/val outputs, assert exactly one mc_* strobe at the next edge, and update last_grant.
- Next state: INST for an IF grant; LOAD or STORE for an LSU grant according to lsu_we.

Busy states (INST/LOAD/STORE):
- The mc_* strobe and all operand outputs are held constant until the matching *_ok is seen, because memctrl re-reads the address every step.
- On ok: drop the strobe at that edge, return to IDLE, and latch the answer (inst → if_data, load → lsu_rdata).
- Pulse if_valid (INST, drop=0) or lsu_done (LOAD/STORE) in the cycle after ok.
- ok inputs not matching the current state are ignored. An ok arriving while IDLE is ignored.
- The cycle after ok always returns to IDLE. memctrl's post-op rest cycle guarantees a stale strobe is never resampled.

Requester contract:
- IF and LSU hold req and operands until their pulse; IF may also release on flush.
- A requester that was just served may re-request immediately. It is arbitrated in the IDLE cycle that follows its pulse.

Flush:
- In IDLE: IF is not granted that cycle.
- In INST: set drop=1; the fetch completes on memctrl, but if_valid is suppressed and if_data is unchanged; drop clears on ok.
- In LOAD/STORE: no effect; stores are never aborted.
- flush and ok in the same cycle: the result is dropped.

Boundaries:
- lsu_len is passed through unmodified.
- A misaligned or out-of-range address is not checked here.
- Reset deasserting mid-operation restarts from IDLE. memctrl is reset by the same event.

Throughput:
- Grant-to-strobe takes 1 cycle.
- Completion adds 1 cycle after ok.
- Back-to-back ops are separated by ≥1 IDLE cycle.

Decomposition:
- const.v gains ARB_IDLE/ARB_INST/ARB_LOAD/ARB_STORE (2-bit) alongside the existing MEMCTRL_* defines.
- No sub-module: the two-way round-robin pick is a few lines of inline logic.

Test Plan:
1. Reset low mid-INST, then release → all mc_* strobes 0 and state IDLE next cycle; first tie after release grants IF (INIT_LAST=1).
2. if_req=1, if_addr=0x100, memctrl model returns 0xDEADBEEF with ok 5 cycles after strobe → mc_read_inst_addr stays 0x100 throughout; if_valid pulses one cycle after ok with if_data=0xDEADBEEF.
3. if_req and lsu_req (load, addr 0x2000, len 3) both held continuously → grants alternate IF, LSU, IF, LSU; lsu_rdata equals the model answer.
4. Store: lsu_we=1, addr 0x30004, len 0, wdata 0x000000AB → mc_write_data_len=0, val=0xAB held until write_ok; lsu_done one pulse; mc_read_* stay 0.
5. flush pulsed 2 cycles into INST → no if_valid for that fetch; the next if_req(0x200) is granted after ok and returns normally.
6. rdy=0 held for 4 cycles mid-LOAD → outputs and state frozen; the op completes correctly after rdy returns.
